// File: rtl/cmlk_bin_packer.sv
// cmlk_bin_packer: multi-lane pixel stream reduction (bypass / average / max binning) and word packer for the DDR write FIFO.
// Build option: define CMLK_BIN_PACKER_HDR_EN to prefix each frame with one 32-bit header word (one input bubble per frame).
module cmlk_bin_packer #(
  parameter int LANES = 4,
  parameter int PIX_W = 16,
  parameter int BIN   = 2
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [LANES*PIX_W-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tuser,
  input  logic                   s_axis_tlast,
  input  logic [1:0]             mode,
  input  logic [1:0]             frame_type_i,
  input  logic                   wr2ddr_en,
  output logic [LANES*PIX_W-1:0] fifo_wrdata,
  output logic                   fifo_wren,
  input  logic                   fifo_full,
  output logic                   fifo_overflow,
  output logic                   unexpected_data,
  output logic [15:0]            frame_cnt
);
  localparam int OUT_W = LANES * PIX_W;
  localparam int GRP   = LANES / BIN;
  localparam int SH    = $clog2(BIN);
  localparam int SUM_W = PIX_W + SH + 1;
  localparam int CW    = $clog2(BIN) + 1;
  localparam int SLICE = OUT_W / BIN;

  // input handshake and frame latches
  logic             acc_s, sof_s;
  logic [1:0]       cur_mode_s;
  logic             tready_q, tready_d;
  logic [1:0]       mode_q, mode_d, ftype_q, ftype_d;
  logic             wr_q, wr_d, seen_sof_q, seen_sof_d, in_line_q, in_line_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             unexp_q, unexp_d;
  // reduction
  logic [OUT_W-1:0] red_data_s;
  logic             red_s;
  logic [SUM_W-1:0] sum_v;
  logic [PIX_W-1:0] max_v, pix_v;
  // stage A
  logic             a_hold_s;
  logic             a_vld_q, a_vld_d, a_red_q, a_red_d, a_sof_q, a_sof_d;
  logic             a_last_q, a_last_d, a_wr_q, a_wr_d;
  logic [OUT_W-1:0] a_data_q, a_data_d;
  // stage B
  logic [OUT_W-1:0] pack_q, pack_d, base_s, merged_s, word_s, hdr_word_s;
  logic [CW-1:0]    cnt_q, cnt_d, base_cnt_s;
  logic             word_due_s, word_wr_s, full_s;
  logic             hdr_sent_q, hdr_sent_d;
  logic             wren_q, wren_d, ovf_q, ovf_d;
  logic [OUT_W-1:0] wrdata_q, wrdata_d;

  // Accept decode; the SOF beat uses its own mode, later beats the latched one
  always_comb begin
    acc_s      = s_axis_tvalid & tready_q;
    sof_s      = acc_s & s_axis_tuser;
    cur_mode_s = sof_s ? mode : mode_q;
  end

  // Horizontal reduction of one beat into the low LANES/B pixel slots
  always_comb begin
    red_data_s = '0;
    red_s      = 1'b0;
    sum_v      = '0;
    max_v      = '0;
    pix_v      = '0;
    case (cur_mode_s)
      2'd1, 2'd2: begin
        red_s = 1'b1;
        for (int k = 0; k < GRP; k++) begin
          sum_v = '0;
          max_v = '0;
          for (int j = 0; j < BIN; j++) begin
            pix_v = s_axis_tdata[(k*BIN+j)*PIX_W +: PIX_W];
            sum_v = sum_v + SUM_W'(pix_v);
            if (pix_v > max_v) max_v = pix_v;
            else               max_v = max_v;
          end
          if (cur_mode_s == 2'd1) red_data_s[k*PIX_W +: PIX_W] = PIX_W'(sum_v >> SH);
          else                    red_data_s[k*PIX_W +: PIX_W] = max_v;
        end
      end
      default: red_data_s = s_axis_tdata;
    endcase
  end

  // Frame control: SOF latching, frame counter, protocol error flag, ready
  always_comb begin
    mode_d      = mode_q;
    ftype_d     = ftype_q;
    wr_d        = wr_q;
    frame_cnt_d = frame_cnt_q;
    seen_sof_d  = seen_sof_q;
    unexp_d     = unexp_q;
    if (sof_s) begin
      mode_d      = mode;
      ftype_d     = frame_type_i;
      wr_d        = wr2ddr_en;
      frame_cnt_d = frame_cnt_q + 16'd1;
      seen_sof_d  = 1'b1;
      unexp_d     = unexp_q | in_line_q;
    end else if (acc_s && !seen_sof_q) begin
      unexp_d = 1'b1;
    end else begin
      unexp_d = unexp_q;
    end
    if (acc_s && (seen_sof_q || s_axis_tuser)) in_line_d = ~s_axis_tlast;
    else                                       in_line_d = in_line_q;
`ifdef CMLK_BIN_PACKER_HDR_EN
    tready_d = ~sof_s;
`else
    tready_d = 1'b1;
`endif
  end

  // Stage A: holds the SOF item one extra cycle while the header goes out
  always_comb begin
`ifdef CMLK_BIN_PACKER_HDR_EN
    a_hold_s = a_vld_q & a_sof_q & ~hdr_sent_q;
`else
    a_hold_s = 1'b0;
`endif
    if (a_hold_s) begin
      a_vld_d  = a_vld_q;
      a_data_d = a_data_q;
      a_red_d  = a_red_q;
      a_sof_d  = a_sof_q;
      a_last_d = a_last_q;
      a_wr_d   = a_wr_q;
    end else begin
      a_vld_d  = acc_s & (seen_sof_q | s_axis_tuser);
      a_data_d = red_data_s;
      a_red_d  = red_s;
      a_sof_d  = sof_s;
      a_last_d = s_axis_tlast;
      a_wr_d   = sof_s ? wr2ddr_en : wr_q;
    end
    hdr_sent_d = a_hold_s;
  end

  // Stage B: single serialised output register for headers, full words and flushes
  always_comb begin
    hdr_word_s = OUT_W'({4'hA, 8'h00, mode_q, ftype_q, frame_cnt_q});
    base_s     = a_sof_q ? '0 : pack_q;
    base_cnt_s = a_sof_q ? '0 : cnt_q;
    merged_s   = base_s | (a_data_q << (32'(base_cnt_s) * SLICE));
    full_s     = a_red_q ? (base_cnt_s == CW'(BIN - 1)) : 1'b1;
    pack_d     = pack_q;
    cnt_d      = cnt_q;
    word_due_s = 1'b0;
    word_wr_s  = 1'b0;
    word_s     = '0;
    wren_d     = 1'b0;
    wrdata_d   = wrdata_q;
    ovf_d      = ovf_q;
    if (a_hold_s) begin
      word_due_s = 1'b1;
      word_wr_s  = wr_q;
      word_s     = hdr_word_s;
    end else if (a_vld_q) begin
      word_wr_s = a_wr_q;
      if (full_s || a_last_q) begin
        word_due_s = 1'b1;
        word_s     = merged_s;
        pack_d     = '0;
        cnt_d      = '0;
      end else begin
        pack_d = merged_s;
        cnt_d  = base_cnt_s + CW'(1);
      end
    end else begin
      word_due_s = 1'b0;
    end
    if (word_due_s && word_wr_s) begin
      if (fifo_full) begin
        ovf_d = 1'b1;
      end else begin
        wren_d   = 1'b1;
        wrdata_d = word_s;
      end
    end else begin
      wren_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      tready_q    <= 1'b0;
      mode_q      <= 2'd0;
      ftype_q     <= 2'd0;
      wr_q        <= 1'b0;
      seen_sof_q  <= 1'b0;
      in_line_q   <= 1'b0;
      frame_cnt_q <= 16'd0;
      unexp_q     <= 1'b0;
      a_vld_q     <= 1'b0;
      a_data_q    <= '0;
      a_red_q     <= 1'b0;
      a_sof_q     <= 1'b0;
      a_last_q    <= 1'b0;
      a_wr_q      <= 1'b0;
      hdr_sent_q  <= 1'b0;
      pack_q      <= '0;
      cnt_q       <= '0;
      wren_q      <= 1'b0;
      wrdata_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      tready_q    <= tready_d;
      mode_q      <= mode_d;
      ftype_q     <= ftype_d;
      wr_q        <= wr_d;
      seen_sof_q  <= seen_sof_d;
      in_line_q   <= in_line_d;
      frame_cnt_q <= frame_cnt_d;
      unexp_q     <= unexp_d;
      a_vld_q     <= a_vld_d;
      a_data_q    <= a_data_d;
      a_red_q     <= a_red_d;
      a_sof_q     <= a_sof_d;
      a_last_q    <= a_last_d;
      a_wr_q      <= a_wr_d;
      hdr_sent_q  <= hdr_sent_d;
      pack_q      <= pack_d;
      cnt_q       <= cnt_d;
      wren_q      <= wren_d;
      wrdata_q    <= wrdata_d;
      ovf_q       <= ovf_d;
    end
  end

  assign s_axis_tready   = tready_q;
  assign fifo_wren       = wren_q;
  assign fifo_wrdata     = wrdata_q;
  assign fifo_overflow   = ovf_q;
  assign unexpected_data = unexp_q;
  assign frame_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_cmlk_bin_packer.sv
// Scoreboard bench for cmlk_bin_packer (LANES=4, PIX_W=16, BIN=2); follows CMLK_BIN_PACKER_HDR_EN when defined.
module tb_cmlk_bin_packer;
`ifdef CMLK_BIN_PACKER_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
  logic [1:0]  mode, frame_type_i;
  logic        wr2ddr_en;
  logic [63:0] fifo_wrdata;
  logic        fifo_wren, fifo_full, fifo_overflow, unexpected_data;
  logic [15:0] frame_cnt;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   a0, a1, a2;

  cmlk_bin_packer #(.LANES(4), .PIX_W(16), .BIN(2)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .mode(mode), .frame_type_i(frame_type_i), .wr2ddr_en(wr2ddr_en),
    .fifo_wrdata(fifo_wrdata), .fifo_wren(fifo_wren), .fifo_full(fifo_full),
    .fifo_overflow(fifo_overflow), .unexpected_data(unexpected_data), .frame_cnt(frame_cnt)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  function automatic logic [63:0] pk4(input logic [15:0] p0, input logic [15:0] p1,
                                      input logic [15:0] p2, input logic [15:0] p3);
    return {p3, p2, p1, p0};
  endfunction

  function automatic logic [63:0] hdrw(input logic [15:0] cnt, input logic [1:0] ft, input logic [1:0] md);
    return {32'h0, 4'hA, 8'h00, md, ft, cnt};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge aclk);
      if (fifo_wren === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_write: got %h at cycle %0d expected no write", fifo_wrdata, cyc);
        end else begin
          e = sb.pop_front();
          chk("word_data", fifo_wrdata, e.data);
          chk("word_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  endtask

  task automatic send(input logic [63:0] d, input logic sof, input logic last, output int acc);
    int guard;
    guard = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = sof;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (s_axis_tready !== 1'b1 && guard < 10) begin
      @(posedge aclk); #1;
      guard++;
    end
    if (guard >= 10) begin
      checks++;
      errors++;
      $display("FAIL tready_timeout: got 0 expected 1");
    end
    acc = cyc;
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(posedge aclk); #1;
      g++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_tready"}, 64'(s_axis_tready), 64'd0);
    chk({name, "_wren"}, 64'(fifo_wren), 64'd0);
    chk({name, "_wrdata"}, fifo_wrdata, 64'd0);
    chk({name, "_ovf"}, 64'(fifo_overflow), 64'd0);
    chk({name, "_unexp"}, 64'(unexpected_data), 64'd0);
    chk({name, "_fcnt"}, 64'(frame_cnt), 64'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none
    areset = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    mode = 2'd0; frame_type_i = 2'd0; wr2ddr_en = 1'b1; fifo_full = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk_all_zero("reset");
    areset = 1'b0;
    chk("tready_cycle_after_reset", 64'(s_axis_tready), 64'd0);
    @(posedge aclk); #1;
    chk("tready_rise", 64'(s_axis_tready), 64'd1);

    // bypass: four beats, one word per beat
    for (int i = 0; i < 4; i++) begin
      send(pk4(16'(4*i), 16'(4*i+1), 16'(4*i+2), 16'(4*i+3)), i == 0, i == 3, a0);
      if (i == 0) begin
        if (HDR == 1) push(hdrw(16'd1, 2'd0, 2'd0), a0 + 2);
        push(pk4(16'd0, 16'd1, 16'd2, 16'd3), a0 + 2 + HDR);
      end else begin
        push(pk4(16'(4*i), 16'(4*i+1), 16'(4*i+2), 16'(4*i+3)), a0 + 2);
      end
    end

    // average binning
    mode = 2'd1;
    send(pk4(16'd10, 16'd20, 16'd7, 16'd8), 1'b1, 1'b0, a0);
    if (HDR == 1) push(hdrw(16'd2, 2'd0, 2'd1), a0 + 2);
    send(pk4(16'd1, 16'd3, 16'd100, 16'd200), 1'b0, 1'b1, a1);
    push(64'h0096_0002_0007_000F, a1 + 2);

    // max binning, odd line; mode changes after SOF must be ignored
    mode = 2'd2;
    send(pk4(16'd5, 16'd9, 16'd3, 16'd1), 1'b1, 1'b0, a0);
    if (HDR == 1) push(hdrw(16'd3, 2'd0, 2'd2), a0 + 2);
    mode = 2'd0;
    send(pk4(16'hFFFF, 16'd2, 16'd4, 16'd8), 1'b0, 1'b0, a1);
    push(64'h0008_FFFF_0003_0009, a1 + 2);
    send(pk4(16'd7, 16'd6, 16'd1, 16'h0100), 1'b0, 1'b1, a2);
    push(64'h0000_0000_0100_0007, a2 + 2);

    // two single-beat frames: header content and the one-cycle bubble
    mode = 2'd1; frame_type_i = 2'd2;
    for (int f = 0; f < 2; f++) begin
      send(pk4(16'd1, 16'd1, 16'd2, 16'd2), 1'b1, 1'b1, a0);
      if (HDR == 1) push(hdrw(16'(4 + f), 2'd2, 2'd1), a0 + 2);
      push(64'h0000_0000_0002_0001, a0 + 2 + HDR);
      chk("tready_after_sof", 64'(s_axis_tready), 64'(1 - HDR));
      @(posedge aclk); #1;
      chk("tready_back", 64'(s_axis_tready), 64'd1);
    end
    chk("frame_cnt_5", 64'(frame_cnt), 64'd5);
    drain();
    chk("ovf_clear", 64'(fifo_overflow), 64'd0);
    chk("unexp_clear", 64'(unexpected_data), 64'd0);

    // FIFO full: both words (and any header) dropped, overflow sticky
    mode = 2'd0; frame_type_i = 2'd0;
    fifo_full = 1'b1;
    send(pk4(16'd1, 16'd2, 16'd3, 16'd4), 1'b1, 1'b0, a0);
    send(pk4(16'd5, 16'd6, 16'd7, 16'd8), 1'b0, 1'b1, a1);
    repeat (5) @(posedge aclk);
    #1;
    fifo_full = 1'b0;
    chk("ovf_set", 64'(fifo_overflow), 64'd1);
    chk("frame_cnt_6", 64'(frame_cnt), 64'd6);
    send(pk4(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD), 1'b1, 1'b1, a0);
    if (HDR == 1) push(hdrw(16'd7, 2'd0, 2'd0), a0 + 2);
    push(64'hDDDD_CCCC_BBBB_AAAA, a0 + 2 + HDR);
    drain();
    chk("ovf_sticky", 64'(fifo_overflow), 64'd1);

    // write-disabled frame: consumed, nothing written, still counted
    wr2ddr_en = 1'b0;
    send(pk4(16'd9, 16'd9, 16'd9, 16'd9), 1'b1, 1'b0, a0);
    wr2ddr_en = 1'b1;
    send(pk4(16'd8, 16'd8, 16'd8, 16'd8), 1'b0, 1'b1, a1);
    repeat (5) @(posedge aclk);
    #1;
    chk("frame_cnt_8", 64'(frame_cnt), 64'd8);

    // reset, then a mid-line SOF that discards the partial word
    areset = 1'b1;
    @(posedge aclk); #1;
    chk_all_zero("reset2_during");
    areset = 1'b0;
    chk_all_zero("reset2_after");
    @(posedge aclk); #1;
    mode = 2'd1;
    send(pk4(16'd2, 16'd2, 16'd4, 16'd4), 1'b1, 1'b0, a0);
    if (HDR == 1) push(hdrw(16'd1, 2'd0, 2'd1), a0 + 2);
    chk("unexp_clean_frame", 64'(unexpected_data), 64'd0);
    send(pk4(16'd10, 16'd12, 16'd20, 16'd22), 1'b1, 1'b0, a1);
    if (HDR == 1) push(hdrw(16'd2, 2'd0, 2'd1), a1 + 2);
    chk("unexp_midline_sof", 64'(unexpected_data), 64'd1);
    send(pk4(16'd30, 16'd32, 16'd40, 16'd40), 1'b0, 1'b1, a2);
    push(64'h0028_001F_0015_000B, a2 + 2);
    drain();

    // reset mid-frame: partial work is lost, later data is unexpected until SOF
    send(pk4(16'd1, 16'd1, 16'd1, 16'd1), 1'b1, 1'b0, a0);
    areset = 1'b1;
    @(posedge aclk); #1;
    chk_all_zero("reset3_during");
    areset = 1'b0;
    @(posedge aclk); #1;
    mode = 2'd0;
    send(pk4(16'd3, 16'd3, 16'd3, 16'd3), 1'b0, 1'b0, a0);
    chk("unexp_pre_sof", 64'(unexpected_data), 64'd1);
    send(pk4(16'd4, 16'd4, 16'd4, 16'd4), 1'b0, 1'b1, a1);
    repeat (4) @(posedge aclk);
    #1;
    chk("unexp_stays", 64'(unexpected_data), 64'd1);
    chk("frame_cnt_pre_sof", 64'(frame_cnt), 64'd0);
    send(64'h1111_2222_3333_4444, 1'b1, 1'b1, a0);
    if (HDR == 1) push(hdrw(16'd1, 2'd0, 2'd0), a0 + 2);
    push(64'h1111_2222_3333_4444, a0 + 2 + HDR);
    drain();
    chk("frame_cnt_after_sof", 64'(frame_cnt), 64'd1);
    chk("unexp_final", 64'(unexpected_data), 64'd1);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmlk_bin_packer.md
# cmlk_bin_packer

Parametrised successor to the camera-link preprocessing datapath. It accepts a multi-lane pixel AXI-stream, applies a runtime-selected horizontal reduction (bypass, average-binning or max-binning), and packs results into full-width words for the DDR write FIFO. Each frame can be preceded by an optional header word. It sits between the camera-link input converter and the DDR write FIFO, and replaces the fixed-width decimate/packet pair.

## Interface
- LANES, 4, pixels per input beat; must be a multiple of BIN.
- PIX_W, 16, bits per pixel, unsigned.
- BIN, 2, horizontal bin factor; legal values 1, 2, 4.
- OUT_W, LANES*PIX_W (derived, not overridable), FIFO word width; must be at least 32.

Ports:
- aclk  in  1  clock.
- areset  in  1  reset: synchronous, active-high. Single clock domain.
- s_axis_tdata  in  LANES*PIX_W  pixels; lane 0 is in the LSBs.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted when tvalid & tready.
- s_axis_tuser  in  1  start of frame, on the first beat of a frame.
- s_axis_tlast  in  1  end of line.
- mode  in  2  0 bypass, 1 average, 2 max, 3 treated as bypass; sampled at SOF.
- frame_type_i  in  2  frame tag; sampled at SOF.
- wr2ddr_en  in  1  frame write enable; sampled at SOF.
- fifo_wrdata  out  OUT_W  packed word.
- fifo_wren  out  1  write strobe.
- fifo_full  in  1  FIFO full.
- fifo_overflow  out  1  sticky: a word was dropped.
- unexpected_data  out  1  sticky: a beat arrived before the first SOF, or tuser arrived mid-line.
- frame_cnt  out  16  count of accepted SOF beats.

## Operation
**Reduction (stage A)**
- The effective bin factor is B = 1 in bypass and B = BIN otherwise.
- Each group of B adjacent lanes (lanes kB..kB+B-1) produces one output pixel k.
- Average: sum >> log2(B), truncated.
- Max: unsigned maximum of the group.
- Each beat yields LANES/B pixels.

**Packing (stage B)**
- Pixels are shifted into a word, with the earliest pixel in the LSBs.
- A word is full after B accepted beats; a full word is emitted.
- At tlast, a partial word is emitted with the unfilled MSBs set to zero, and the pack counter clears.
- At most one word is emitted per beat.

**Frame control**
- The SOF beat latches mode, frame_type_i and wr2ddr_en, and increments frame_cnt (wraps 0xFFFF→0).
- A SOF beat arriving mid-line discards the partial word, sets unexpected_data, and starts a new frame.
- Beats arriving before the first SOF after reset are consumed and discarded, and set unexpected_data.
- If wr2ddr_en was latched 0, the frame's header and data words are consumed but not written.

**Overflow**
- When a word is due and fifo_full=1, the word is dropped: fifo_wren stays 0 and fifo_overflow is set.
- fifo_overflow is sticky until areset.

## Timing
- During areset and in the cycle after it, all outputs are 0.
- s_axis_tready rises in the first cycle after areset deasserts.
- Latency: a beat accepted in cycle N produces its word (if any) at fifo_wren in cycle N+2.
- Without the header: s_axis_tready=1 at all times outside reset, so stage B never back-pressures.
- With the header:
  - When stage A holds the SOF item in cycle N+1, s_axis_tready=0 in that cycle.
  - The header is written at N+2, and the SOF beat's word at N+3.
  - This single bubble per frame is the only back-pressure.
- A flush word from the previous line and a header never collide, because stage B is a single serialised output register.
- areset asserted mid-frame:
  - Clears the pipeline, pack state, sticky flags and frame_cnt.
  - Discards partial words.
  - Data after reset is treated as unexpected until the next SOF.
- Simultaneous tlast and a full word: emit one word, the full word, with no extra flush.

## Configuration
- CMLK_BIN_PACKER_HDR_EN defined: one header word is inserted before each frame's data, subject to wr2ddr_en.
  - Header format: [15:0] frame_cnt after increment, [17:16] frame_type, [19:18] mode, [27:20] 0, [31:28] 4'hA, upper bits 0.
  - Costs one input bubble per frame.
- Not defined:
  - No header and no bubble.
  - s_axis_tready is constant 1 outside reset.
  - frame_cnt is still maintained.

## Test plan
- Bypass, defaults, 4-beat line of incrementing 16-bit pixels 0..15, wr2ddr_en=1 → 4 words, first 0x0003_0002_0001_0000, each at N+2.
- Average mode, lanes {10,20,7,8}, {1,3,100,200} → one word 0x0096_0002_0007_000F.
- Max mode, line of 3 beats (odd) with tlast → one full word, then a flush word with the upper 32 bits zero.
- HDR_EN, two frames, frame_type_i=2, mode=1 → header 0xA00_6_0001 then 0xA00_6_0002, tready low exactly one cycle after each SOF.
- fifo_full held high for 2 word slots → those words are absent, fifo_overflow=1 stays high; wr2ddr_en=0 frame → zero writes, frame_cnt still increments.
- Data before the first SOF, then a mid-line tuser, then areset mid-frame → unexpected_data=1 after the first beat, stays set, and all outputs and frame_cnt are 0 after reset.
